count_10: RTL and testbench

Synchronous 4-bit decade counter. Advances by one on every rising clock edge, wrapping from 9 back to 0. A synchronous active-high reset returns it to 0. Serves as a timing and sequencing primitive, such as a digit counter or sub-cycle step counter, inside the CPU datapath and its support logic.

---
 rtl/count_10.sv | 30 +++
 tb/tb_count_10.sv | 111 +++++++++++
 2 files changed

// File: rtl/count_10.sv
// count_10: synchronous decade counter (0..MODULUS-1) with synchronous active-high reset.
// Serves as a digit or sub-cycle step counter; count is driven straight from the register.
module count_10 #(
  parameter int unsigned MODULUS = 10,
  parameter int unsigned WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  // Power-up value is 0 so counting is defined even if rst is never asserted.
  logic [WIDTH-1:0] count_q = '0;

  // Terminal and out-of-range values both load 0, so an upset self-clears in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (count_q >= LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_count_10.sv
// tb_count_10: directed-vector bench for count_10 with hand-computed expected counts.
`timescale 1ps/1ps
module tb_count_10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;

  int checks   = 0;
  int failures = 0;

  count_10 dut (
    .clk   (clk),
    .rst   (rst),
    .count (count)
  );

  always #500 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: count=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;

    // Power-up value, before any edge.
    #250;
    check("powerup", count, 4'd0);

    // Free run for 12 edges: 1..9,0,1,2.
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("freerun_%0d", i), count, 4'(i % 10));
    end

    // Advance 2 -> 9, then wrap to 0 and on to 1.
    for (int i = 3; i <= 9; i++) begin
      step();
      check($sformatf("to9_%0d", i), count, 4'(i));
    end
    step();
    check("wrap_0", count, 4'd0);
    step();
    check("wrap_1", count, 4'd1);

    // Advance 1 -> 5, reset for one edge, release.
    for (int i = 2; i <= 5; i++) begin
      step();
      check($sformatf("to5_%0d", i), count, 4'(i));
    end
    rst = 1'b1;
    step();
    check("midreset", count, 4'd0);
    rst = 1'b0;
    step();
    check("midreset_release", count, 4'd1);

    // Reset held for 4 edges, then counts 1,2,3.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("held_%0d", i), count, 4'd0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("after_held_%0d", i), count, 4'(i));
    end

    // Short rst pulse entirely between rising edges has no effect.
    #100 rst = 1'b1;
    #200 rst = 1'b0;
    check("pulse_no_comb", count, 4'd3);
    step();
    check("pulse_ignored", count, 4'd4);

    // Advance 4 -> 9, then reset coincident with wrap.
    for (int i = 5; i <= 9; i++) begin
      step();
      check($sformatf("to9b_%0d", i), count, 4'(i));
    end
    rst = 1'b1;
    step();
    check("reset_at_9", count, 4'd0);
    rst = 1'b0;
    step();
    check("reset_at_9_release", count, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
